card_turn_controller: RTL and testbench

//  Sequences one player turn of the 6x6 memory card game: pick card one, pick card two,

---
 rtl/card_turn_controller.sv | 174 +++++++++++++++++
 tb/tb_card_turn_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_turn_controller.sv
// ============================================================================
// Module  : card_turn_controller
// Purpose : One player turn of the memory card game (pick, pick, compare, hold).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module card_turn_controller #(
    parameter int NUM_CARDS   = 36,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int TURN_W      = 10
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_btn_a,
    input  logic [5:0]           i_cursor,
    output logic [5:0]           o_mem_addr,
    input  logic [4:0]           i_mem_rd_data,
    output logic [5:0]           o_card1_idx,
    output logic [5:0]           o_card2_idx,
    output logic [2:0]           o_state_out,
    output logic [NUM_CARDS-1:0] o_matched,
    output logic [4:0]           o_pairs_found,
    output logic [TURN_W-1:0]    o_turns,
    output logic                 o_match_pulse,
    output logic                 o_miss_pulse,
    output logic                 o_hold_active,
    output logic                 o_game_over
);

    localparam int unsigned          c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]           c_ALL_PAIRS = 5'(NUM_CARDS / 2);
    localparam logic [6:0]           c_NUM_CARDS = 7'(NUM_CARDS);

    typedef enum logic [2:0] {
        ST_PICK1 = 3'd0,
        ST_READ1 = 3'd1,
        ST_CAP1  = 3'd2,
        ST_PICK2 = 3'd3,
        ST_READ2 = 3'd4,
        ST_CAP2  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t                r_state;
    logic                  r_btn_q;
    logic [5:0]            r_mem_addr;
    logic [5:0]            r_card1_idx;
    logic [5:0]            r_card2_idx;
    logic [4:0]            r_face1;
    logic [NUM_CARDS-1:0]  r_matched;
    logic [4:0]            r_pairs;
    logic [TURN_W-1:0]     r_turns;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_match_pulse;
    logic                  r_miss_pulse;
    logic                  r_hold_active;
    logic                  r_game_over;

    logic                  w_pick;
    logic                  w_free;
    logic                  w_valid1;
    logic                  w_valid2;
    logic [NUM_CARDS-1:0]  w_pair_mask;

    // Cursor values beyond the last slot never match a loop index, so they read as not free.
    always_comb begin
        w_free      = 1'b0;
        w_pair_mask = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (i_cursor == 6'(i)) begin
                w_free = ~r_matched[i];
            end
            if ((r_card1_idx == 6'(i)) || (r_card2_idx == 6'(i))) begin
                w_pair_mask[i] = 1'b1;
            end
        end
        w_pick   = i_btn_a & ~r_btn_q;
        w_valid1 = w_pick & ({1'b0, i_cursor} < c_NUM_CARDS) & w_free;
        w_valid2 = w_valid1 & (i_cursor != r_card1_idx);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_PICK1;
            r_btn_q       <= 1'b1;
            r_mem_addr    <= '0;
            r_card1_idx   <= '0;
            r_card2_idx   <= '0;
            r_face1       <= '0;
            r_matched     <= '0;
            r_pairs       <= '0;
            r_turns       <= '0;
            r_hold_cnt    <= '0;
            r_match_pulse <= 1'b0;
            r_miss_pulse  <= 1'b0;
            r_hold_active <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_btn_q       <= i_btn_a;
            r_match_pulse <= 1'b0;
            r_miss_pulse  <= 1'b0;
            case (r_state)
                ST_PICK1: begin
                    if (w_valid1) begin
                        r_card1_idx <= i_cursor;
                        r_mem_addr  <= i_cursor;
                        r_state     <= ST_READ1;
                    end
                end
                ST_READ1: r_state <= ST_CAP1;
                ST_CAP1: begin
                    r_face1 <= i_mem_rd_data;
                    r_state <= ST_PICK2;
                end
                ST_PICK2: begin
                    if (w_valid2) begin
                        r_card2_idx <= i_cursor;
                        r_mem_addr  <= i_cursor;
                        r_state     <= ST_READ2;
                    end
                end
                ST_READ2: r_state <= ST_CAP2;
                ST_CAP2: begin
                    if (r_turns != {TURN_W{1'b1}}) begin
                        r_turns <= r_turns + 1'b1;
                    end
                    if (i_mem_rd_data == r_face1) begin
                        r_match_pulse <= 1'b1;
                        r_matched     <= r_matched | w_pair_mask;
                        r_pairs       <= r_pairs + 5'd1;
                    end else begin
                        r_miss_pulse  <= 1'b1;
                    end
                    r_hold_cnt    <= c_HOLD_LOAD;
                    r_hold_active <= 1'b1;
                    r_state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_hold_active <= 1'b0;
                        if (r_pairs == c_ALL_PAIRS) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state     <= ST_PICK1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_PICK1;
            endcase
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_card1_idx   = r_card1_idx;
    assign o_card2_idx   = r_card2_idx;
    assign o_state_out   = r_state;
    assign o_matched     = r_matched;
    assign o_pairs_found = r_pairs;
    assign o_turns       = r_turns;
    assign o_match_pulse = r_match_pulse;
    assign o_miss_pulse  = r_miss_pulse;
    assign o_hold_active = r_hold_active;
    assign o_game_over   = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_card_turn_controller.sv
// ============================================================================
// Module  : tb_card_turn_controller
// Purpose : Randomised scoreboard bench for card_turn_controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_turn_controller;

    localparam int N     = 36;
    localparam int HOLD  = 4;
    localparam int TW    = 10;
    localparam int TMAX  = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b1;
    logic [5:0]    cursor = '0;
    logic [5:0]    mem_addr;
    logic [4:0]    rd_data = '0;
    logic [5:0]    card1, card2;
    logic [2:0]    state;
    logic [N-1:0]  matched;
    logic [4:0]    pairs;
    logic [TW-1:0] turns;
    logic          mp, xp, hold, gover;

    card_turn_controller #(.NUM_CARDS(N), .HOLD_CYCLES(HOLD), .TURN_W(TW)) dut (
        .i_clock(clk), .i_reset(rst), .i_btn_a(btn), .i_cursor(cursor),
        .o_mem_addr(mem_addr), .i_mem_rd_data(rd_data),
        .o_card1_idx(card1), .o_card2_idx(card2), .o_state_out(state),
        .o_matched(matched), .o_pairs_found(pairs), .o_turns(turns),
        .o_match_pulse(mp), .o_miss_pulse(xp), .o_hold_active(hold), .o_game_over(gover)
    );

    always #5 clk = ~clk;

    logic [4:0] ram [0:N-1];
    int perm [18] = '{15, 1, 2, 4, 7, 3, 9, 8, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20};

    always @(posedge clk) rd_data <= (mem_addr < 6'(N)) ? ram[mem_addr] : 5'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: game-level bookkeeping, one entry per completed compare.
    typedef struct {
        bit              m;
        int              c1;
        int              c2;
        int              pairs;
        int              turns;
        longint unsigned mv;
    } exp_t;
    exp_t sbq[$];

    int              m_phase;      // 0 waiting first pick, 1 waiting second, 2 game over
    int              m_c1;
    int              m_pairs;
    int              m_turns;
    int              m_addr;
    int              m_pushed;
    longint unsigned m_matched;

    task automatic model_reset();
        m_phase = 0; m_c1 = 0; m_pairs = 0; m_turns = 0; m_addr = 0; m_pushed = 0; m_matched = 0;
    endtask

    function automatic bit model_valid(int cur);
        return (m_phase != 2) && (cur < N) && !m_matched[cur] && !(m_phase == 1 && cur == m_c1);
    endfunction

    task automatic model_second(int cur);
        exp_t e;
        bit   m;
        m = (ram[cur] == ram[m_c1]);
        if (m_turns < TMAX) m_turns++;
        if (m) begin
            m_matched[cur]  = 1'b1;
            m_matched[m_c1] = 1'b1;
            m_pairs++;
        end
        e = '{m, m_c1, cur, m_pairs, m_turns, m_matched};
        sbq.push_back(e);
        m_pushed++;
        m_addr  = cur;
        m_phase = (m_pairs == N / 2) ? 2 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(int cur);
        cursor = 6'(cur);
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_state"}, state, (m_phase == 0) ? 0 : (m_phase == 1) ? 3 : 7);
        chk({tag, "_pairs"}, pairs, m_pairs);
        chk({tag, "_turns"}, turns, m_turns);
        chk({tag, "_matched"}, matched, m_matched);
        chk({tag, "_game_over"}, gover, m_phase == 2);
        chk({tag, "_mem_addr"}, mem_addr, m_addr);
        chk({tag, "_hold"}, hold, 0);
        if (m_phase == 1) chk({tag, "_card1"}, card1, m_c1);
    endtask

    // busy=1 raises the button once while the turn is still being processed.
    task automatic do_pick(int cur, bit busy);
        bit v;
        v = model_valid(cur);
        press(cur);
        if (!v) begin
            tick();
        end else if (m_phase == 0) begin
            m_c1   = cur;
            m_addr = cur;
            m_phase = 1;
            btn = busy;
            tick();
            btn = 1'b0;
            tick();
        end else begin
            model_second(cur);
            for (int i = 0; i < 6; i++) begin
                btn = busy && (i == 2);
                tick();
            end
            btn = 1'b0;
        end
        check_idle("pick");
    endtask

    function automatic int partner(int c);
        return (c < 18) ? c + 18 : c - 18;
    endfunction

    task automatic check_all_zero(string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_outs"}, {mem_addr, card1, card2, pairs, turns, mp, xp, hold, gover}, 0);
        chk({tag, "_matched"}, matched, 0);
    endtask

    // Scoreboard monitor: pops one entry per compare strobe, measures HOLD length.
    int hold_run = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_run = 0;
            end else begin
                if (hold) hold_run++;
                else if (hold_run != 0) begin
                    chk("hold_len", hold_run, HOLD);
                    hold_run = 0;
                end
                if (mp || xp) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_pulse", {mp, xp}, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_pulse", {mp, xp}, e.m ? 2 : 1);
                        chk("sb_card1", card1, e.c1);
                        chk("sb_card2", card2, e.c2);
                        chk("sb_pairs", pairs, e.pairs);
                        chk("sb_turns", turns, e.turns);
                        chk("sb_matched", matched, e.mv);
                        chk("sb_state_hold", {state, hold}, {3'd6, 1'b1});
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cur, r, guard;
        for (int i = 0; i < N; i++) ram[i] = 5'(perm[i % 18]);
        model_reset();

        // Reset with the button held, then release reset still holding it.
        rst = 1'b1; btn = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick(); tick();
        chk("held_btn_state", state, 0);
        chk("held_btn_addr", mem_addr, 0);
        btn = 1'b0;
        tick();

        // Matching pair, then picks on a matched card and an out-of-range cursor.
        do_pick(0, 1'b0);
        do_pick(18, 1'b0);
        do_pick(0, 1'b0);
        do_pick(40, 1'b0);
        chk("ignored_addr", mem_addr, 18);

        // Same card twice, then a mismatch; presses during read/hold are dropped.
        do_pick(5, 1'b1);
        do_pick(5, 1'b0);
        chk("same_card_state", state, 3);
        do_pick(6, 1'b1);

        // Reach three pairs, then reset in the middle of HOLD.
        do_pick(1, 1'b0); do_pick(19, 1'b0);
        do_pick(2, 1'b0); do_pick(20, 1'b0);
        do_pick(3, 1'b0);
        chk("pre_reset_pairs", pairs, 3);
        press(4);
        model_second(4);
        tick(); tick();
        chk("in_hold", {state, hold}, {3'd6, 1'b1});
        rst = 1'b1;
        tick();
        check_all_zero("mid_hold_reset");
        rst = 1'b0;
        model_reset();
        tick();

        // Randomised play, then finish off any remaining pairs.
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 9);
            if (m_phase == 1 && r < 5) cur = partner(m_c1);
            else if (r < 8)            cur = $urandom_range(0, N - 1);
            else                       cur = $urandom_range(0, 63);
            do_pick(cur, $urandom_range(0, 3) == 0);
        end
        guard = 0;
        while (m_phase != 2 && guard < 100) begin
            if (m_phase == 1) cur = partner(m_c1);
            else begin
                cur = 0;
                while (m_matched[cur]) cur++;
            end
            do_pick(cur, 1'b0);
            guard++;
        end
        chk("final_game_over", gover, 1);
        chk("final_pairs", pairs, N / 2);
        chk("final_turns", turns, m_pushed);
        do_pick(7, 1'b0);
        do_pick(30, 1'b0);
        chk("done_absorbing", state, 7);

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
